// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Transmit-side controller for the memory-mapped UART data port. Bytes
// written by the CPU are buffered in a small circular FIFO and handed to
// the UART transmit core one at a time using a start/busy handshake.
// `ready` is the bus status bit (FIFO not full) so software can poll for
// space instead of tracking transmitter timing.
//
// Optional feature: define UART_TX_CRLF_EN to expand every 0x0A (LF) into
// the pair 0x0D 0x0A (CR LF) on the wire. The LF is launched from an
// internal hold register, so the pair costs a single FIFO pop.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   PTR_W    log2(DEPTH)
// Ports
//   clk        clock, all state updates on the rising edge
//   rstn       asynchronous active-low reset
//   wr_en      byte write strobe from the bus (one byte per cycle)
//   wr_data    byte to enqueue, sampled when wr_en is high
//   flush      synchronous clear of FIFO contents and overflow
//   tx_busy    transmitter is shifting a frame
//   tx_start   one-cycle launch pulse to the transmitter
//   tx_data    byte for the transmitter, stable from tx_start until busy falls
//   ready      FIFO not full (combinational from level)
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky: a write was dropped because the FIFO was full

module uart_tx_scheduler #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             flush,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             ready,
  output logic [PTR_W:0]   level,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             overflow_reg;
  logic             tx_start_reg;
  logic [7:0]       tx_data_reg;

  logic full;
  logic empty;
  logic push;
  logic drop;
  logic pop;

`ifdef UART_TX_CRLF_EN
  logic       lf_pending_reg;
  logic [7:0] lf_hold_reg;
  logic       send_lf;
`endif

  // full/empty are taken from the registered level, i.e. the state at the
  // start of the cycle; a pop in the same cycle does not make room for a
  // write. A write coinciding with flush is discarded outright.
  assign full  = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign push  = wr_en && !full && !flush;
  assign drop  = wr_en &&  full && !flush;

  assign ready    = !full;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

  // Next-state logic. A pop is suppressed in a flush cycle so that bytes
  // being flushed are never started.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
    send_lf    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_CRLF_EN
          // CR has gone out; launch the held LF without touching the FIFO.
          if (lf_pending_reg) begin
            send_lf    = 1'b1;
            state_next = LAUNCH;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage array without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= 8'h00;
`ifdef UART_TX_CRLF_EN
      lf_pending_reg <= 1'b0;
      lf_hold_reg    <= 8'h00;
`endif
    end else begin
      // Registered pulse: high for exactly the cycle spent in LAUNCH.
      tx_start_reg <= (state_next == LAUNCH);

      if (pop) begin
`ifdef UART_TX_CRLF_EN
        if (mem[rd_ptr_reg] == 8'h0A) begin
          tx_data_reg    <= 8'h0D;
          lf_hold_reg    <= mem[rd_ptr_reg];
          lf_pending_reg <= 1'b1;
        end else begin
          tx_data_reg    <= mem[rd_ptr_reg];
        end
`else
        tx_data_reg <= mem[rd_ptr_reg];
`endif
      end

`ifdef UART_TX_CRLF_EN
      if (send_lf) begin
        tx_data_reg    <= lf_hold_reg;
        lf_pending_reg <= 1'b0;
      end
`endif

      // Flush clears the queue but leaves the FSM and tx_data alone so an
      // in-flight byte finishes normally.
      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        level_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
          2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
          default: level_reg <= level_reg;
        endcase
        if (drop) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: directed scenarios, each in its own task,
// with a small transmitter model that raises busy for a fixed frame time
// after every tx_start and logs every launched byte.

module tb_uart_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             flush = 1'b0;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             ready;
  logic [PTR_W:0]   level;
  logic             overflow;

  int checks = 0;
  int failures = 0;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] sent_q[$];

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ready    (ready),
    .level    (level),
    .overflow (overflow)
  );

  // Transmitter model: busy rises in the launch cycle and lasts 4 negedges;
  // hold_busy freezes the transmitter as busy.
  always @(negedge clk) begin
    if (tx_start) begin
      sent_q.push_back(tx_data);
      $display("tx_start data=%02h", tx_data);
      busy_cnt = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    $display("write data=%02h level=%0d ready=%0b overflow=%0b", d, level, ready, overflow);
  endtask

  task automatic drain(input int n);
    int cyc;
    cyc = 0;
    while (!(sent_q.size() >= n && !tx_busy && level == 0) && cyc < 400) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 400) begin
      failures++;
      $display("FAIL drain_timeout: sent=%0d required=%0d", sent_q.size(), n);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    hold_busy = 1'b0;
    repeat (3) tick();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
    rstn = 1'b1;
    tick();

    // Park the FSM in WAIT_DONE with one byte still queued, then reset.
    hold_busy = 1'b1;
    sent_q.delete();
    write_byte(8'h55);
    write_byte(8'h66);
    repeat (4) tick();
    checks++; if (sent_q.size() != 1) begin failures++; $display("FAIL midframe_launches: got %0d want 1", sent_q.size()); end
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL midframe_level: got %0d want 1", level); end
    rstn = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midreset_tx_start: got %0b want 0", tx_start); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL midreset_level: got %0d want 0", level); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %0b want 1", ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midreset_overflow: got %0b want 0", overflow); end
    tick();
    hold_busy = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (20) tick();
    checks++; if (sent_q.size() != 1) begin failures++; $display("FAIL post_reset_quiet: launches %0d want 1", sent_q.size()); end
  endtask

  task automatic test_single_byte;
    sent_q.delete();
    write_byte(8'h41);
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL single_level_after_write: got %0d want 1", level); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_early: got %0b want 0", tx_start); end
    tick();
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL single_level_after_pop: got %0d want 0", level); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start_pulse: got %0b want 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_tx_data: got %02h want 41", tx_data); end
    tick();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_width: got %0b want 0", tx_start); end
    drain(1);
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'h41) begin failures++; $display("FAIL single_sequence: count %0d want 1 byte 41", sent_q.size()); end
  endtask

  task automatic test_fill_drop;
    logic [7:0] exp_b;
    sent_q.delete();
    hold_busy = 1'b1;
    write_byte(8'hA0);
    repeat (4) tick();
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      $display("write data=%02h level=%0d ready=%0b overflow=%0b", wr_data, level, ready, overflow);
      if (i == 6) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready_at_7: got %0b want 1", ready); end
      end
      if (i == 7) begin
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fill_ready_at_8: got %0b want 0", ready); end
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level_at_8: got %0d want 8", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow_early: got %0b want 0", overflow); end
      end
    end
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow: got %0b want 1", overflow); end
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level_after_drop: got %0d want 8", level); end
    hold_busy = 1'b0;
    drain(9);
    checks++; if (sent_q.size() != 9) begin failures++; $display("FAIL fill_count: got %0d want 9", sent_q.size()); end
    for (int k = 0; k < 9 && k < sent_q.size(); k++) begin
      exp_b = (k == 0) ? 8'hA0 : 8'(k - 1);
      checks++; if (sent_q[k] !== exp_b) begin failures++; $display("FAIL fill_byte[%0d]: got %02h want %02h", k, sent_q[k], exp_b); end
    end

    // Second fill starts at pointer 1, so it crosses the wrap point.
    sent_q.delete();
    hold_busy = 1'b1;
    write_byte(8'hB0);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      write_byte(8'h10 + 8'(i));
    end
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL wrap_level: got %0d want 8", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL wrap_overflow_sticky: got %0b want 1", overflow); end
    hold_busy = 1'b0;
    drain(9);
    checks++; if (sent_q.size() != 9) begin failures++; $display("FAIL wrap_count: got %0d want 9", sent_q.size()); end
    for (int k = 0; k < 9 && k < sent_q.size(); k++) begin
      exp_b = (k == 0) ? 8'hB0 : 8'h10 + 8'(k - 1);
      checks++; if (sent_q[k] !== exp_b) begin failures++; $display("FAIL wrap_byte[%0d]: got %02h want %02h", k, sent_q[k], exp_b); end
    end
  endtask

  task automatic test_push_pop;
    logic [7:0] exp_b;
    sent_q.delete();
    hold_busy = 1'b1;
    write_byte(8'hC0);
    repeat (4) tick();
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL pushpop_setup_level: got %0d want 3", level); end
    repeat (2) tick();
    // Busy drops before the next edge: FSM returns to IDLE on it, and the
    // edge after that pops, which is where the write is aimed.
    hold_busy = 1'b0;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'hC4;
    tick();
    wr_en   = 1'b0;
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL pushpop_level: got %0d want 3", level); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL pushpop_start: got %0b want 1", tx_start); end
    checks++; if (tx_data !== 8'hC1) begin failures++; $display("FAIL pushpop_tx_data: got %02h want c1", tx_data); end
    drain(5);
    checks++; if (sent_q.size() != 5) begin failures++; $display("FAIL pushpop_count: got %0d want 5", sent_q.size()); end
    for (int k = 0; k < 5 && k < sent_q.size(); k++) begin
      exp_b = 8'hC0 + 8'(k);
      checks++; if (sent_q[k] !== exp_b) begin failures++; $display("FAIL pushpop_byte[%0d]: got %02h want %02h", k, sent_q[k], exp_b); end
    end
  endtask

  task automatic test_flush;
    sent_q.delete();
    hold_busy = 1'b1;
    write_byte(8'hD0);
    repeat (4) tick();
    for (int i = 0; i < 9; i++) begin
      write_byte(8'hD1 + 8'(i));
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL flush_setup_overflow: got %0b want 1", overflow); end
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    $display("flush level=%0d overflow=%0b", level, overflow);
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL flush_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow: got %0b want 0", overflow); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %0b want 1", ready); end
    checks++; if (tx_data !== 8'hD0) begin failures++; $display("FAIL flush_inflight_data: got %02h want d0", tx_data); end
    hold_busy = 1'b0;
    repeat (30) tick();
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'hD0) begin failures++; $display("FAIL flush_sequence: count %0d want 1 byte d0", sent_q.size()); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL flush_level_final: got %0d want 0", level); end
  endtask

  task automatic test_crlf;
    logic [7:0] exp_q[$];
`ifdef UART_TX_CRLF_EN
    exp_q = '{8'h0D, 8'h0A, 8'h42};
`else
    exp_q = '{8'h0A, 8'h42};
`endif
    sent_q.delete();
    write_byte(8'h0A);
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL lf_level_write: got %0d want 1", level); end
    tick();
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL lf_level_pop: got %0d want 0", level); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL lf_start: got %0b want 1", tx_start); end
    checks++; if (tx_data !== exp_q[0]) begin failures++; $display("FAIL lf_first_data: got %02h want %02h", tx_data, exp_q[0]); end
    write_byte(8'h42);
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL lf_level_queued: got %0d want 1", level); end
    drain(exp_q.size());
    checks++; if (sent_q.size() != exp_q.size()) begin failures++; $display("FAIL lf_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < sent_q.size(); k++) begin
      checks++; if (sent_q[k] !== exp_q[k]) begin failures++; $display("FAIL lf_byte[%0d]: got %02h want %02h", k, sent_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_drop();
    test_push_pop();
    test_flush();
    test_crlf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
